div_datapath: RTL
=================

# div_datapath

Remainder/divisor datapath for the 32-bit sequential divider, directly downstream of the divider `Control` FSM. It consumes `Control`'s `wrctrl`, `ozctrl`, `ALUfunction`, `ready_wait` and `ready` strobes and returns `fsb`, the sign bit of the working remainder, which `Control` uses for its next decision. It holds a 64-bit remainder register, a 32-bit divisor register and an internal add/subtract unit, and latches the final quotient and remainder.

## Interface
- `WIDTH`, 32: operand width; the remainder register is `2*WIDTH` bits.
- `MAXSHIFT`, 33: number of shifts allowed per operation before `err` is raised.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: start; loads the operands.
- `dividend` in WIDTH: dividend, sampled when `run`=1.
- `divisor` in WIDTH: divisor, sampled when `run`=1.
- `ALUfunction` in 6: 6'b100000 = ADD, 6'b100010 = SUB; any other code = hold.
- `wrctrl` in 1: write the ALU result into the upper half.
- `ozctrl` in 1: bit shifted into the LSB on a shift cycle.
- `ready_wait` in 1: final right-shift of the upper half.
- `ready` in 1: operation complete; capture the results.
- `fsb` out 1: `rem[2*WIDTH-1]`, combinational from the register.
- `quotient` out WIDTH: latched quotient.
- `remainder` out WIDTH: latched remainder.
- `done` out 1: one-cycle pulse after the results are captured.
- `busy` out 1: high from `run` until `ready`.
- `err` out 1: sticky protocol error.

## Operation
- Registers:
  - `rem` (64 bits), `dsr` (32 bits), `shcnt` (6 bits).
  - ALU output = `rem[63:32] ± dsr`, computed modulo 2^32 with carry discarded. Hold codes pass `rem[63:32]` through.
- Action per rising edge. Priority order: `run` > `ready` > `ready_wait` > `wrctrl` > shift.
  - `run`:
    - `rem <= {31'b0, dividend, 1'b0}`, `dsr <= divisor`, `shcnt <= 0`.
    - `busy <= 1`, `err <= 0`.
    - This also restarts an operation already in progress.
  - `ready` while `busy`:
    - `quotient <= rem[31:0]`, `remainder <= rem[63:32]`.
    - `busy <= 0`, `done <= 1` for exactly one cycle.
  - `ready_wait` while `busy`: `rem[63:32] <= {1'b0, rem[63:33]}`; `rem[31:0]` is unchanged.
  - `wrctrl` while `busy`: `rem[63:32] <= ALU output`.
  - Otherwise, while `busy`:
    - Shift: `rem <= {rem[62:0], ozctrl}`, `shcnt <= shcnt+1`.
    - If `shcnt` would exceed `MAXSHIFT`, set `err <= 1`; the shift still occurs.
  - Not `busy`: `rem` holds. `ready`, `ready_wait` and `wrctrl` are ignored.
- `ready` arriving without a preceding `run` (not `busy`): `err <= 1`, outputs unchanged, no `done`.
- One restoring iteration, as sequenced by `Control`:
  - SUB with `wrctrl` → check `fsb` → if `fsb`=1, ADD with `wrctrl` → shift with `ozctrl = ~fsb_at_decision`.
  - The final shifts leave the remainder one bit too far left; `ready_wait` corrects this.

## Timing
- Reset values:
  - `rem` = 0, `dsr` = 0, `shcnt` = 0.
  - `quotient` = 0, `remainder` = 0.
  - `done` = 0, `busy` = 0, `err` = 0, `fsb` = 0.
- `fsb` reflects the register contents the cycle after each write, with no extra latency.
- `quotient`/`remainder` update on the edge where `ready`=1. `done` is high in the following cycle only. Results hold until the next `ready`.
- `rst` asserted mid-operation clears everything immediately (asynchronous). `busy` is 0 after release.
- `run` and `ready` in the same cycle: `run` wins, no capture, no `done`.
- `wrctrl` and `ready_wait` in the same cycle: `ready_wait` wins.

## Configuration
- `DIV_DIVZERO_EN` defined:
  - `run` with `divisor`=0 sets sticky `dz`, an extra output port, reset 0.
  - The next `ready` captures `quotient` = all-ones and `remainder` = the latched dividend, regardless of `rem`.
  - `dz` clears on the next `run`.
- Undefined: no `dz` port. A divide-by-zero produces whatever the ALU sequence yields, with no special casing.

## Test plan
- Reset: `rst`=1 mid-operation → all outputs 0 in the same cycle; `busy`=0 after release.
- 7 ÷ 2 with the full `Control`-style iteration sequence, 32 iterations plus `ready_wait` and `ready` → `quotient`=3, `remainder`=1, `done` pulses once.
- 0xFFFFFFFF ÷ 0x10 → `quotient`=0x0FFFFFFF, `remainder`=0xF; the ALU subtraction wraps without a carry-out effect.
- `run` and `ready` in the same cycle during an operation → registers reload, no `done`, previous results unchanged.
- 34 shift cycles with no `ready` → `err`=1 after the 34th shift; the next `run` clears it. `ready` with `busy`=0 → `err`=1, no `done`.
- `DIV_DIVZERO_EN`: 5 ÷ 0 → `dz`=1 after `run`, `quotient`=0xFFFFFFFF, `remainder`=5 at `ready`. Without the macro, no `dz` port.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the divider Control FSM and the remainder/divisor datapath.
// DIV_DIVZERO_EN adds the sticky divide-by-zero flag dz.
interface div_if #(parameter int WIDTH = 32);
    logic             run;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [5:0]       ALUfunction;
    logic             wrctrl;
    logic             ozctrl;
    logic             ready_wait;
    logic             ready;
    logic             fsb;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             err;
`ifdef DIV_DIVZERO_EN
    logic             dz;

    modport master (
        output run, dividend, divisor, ALUfunction, wrctrl, ozctrl, ready_wait, ready,
        input  fsb, quotient, remainder, done, busy, err, dz
    );
    modport slave (
        input  run, dividend, divisor, ALUfunction, wrctrl, ozctrl, ready_wait, ready,
        output fsb, quotient, remainder, done, busy, err, dz
    );
`else
    modport master (
        output run, dividend, divisor, ALUfunction, wrctrl, ozctrl, ready_wait, ready,
        input  fsb, quotient, remainder, done, busy, err
    );
    modport slave (
        input  run, dividend, divisor, ALUfunction, wrctrl, ozctrl, ready_wait, ready,
        output fsb, quotient, remainder, done, busy, err
    );
`endif
endinterface

// File: rtl/div_datapath.sv
// Remainder/divisor datapath of the restoring sequential divider; fsb feeds back to Control.
// DIV_DIVZERO_EN: divide-by-zero detection with forced all-ones quotient (dz output).
module div_datapath #(
    parameter int WIDTH    = 32,
    parameter int MAXSHIFT = 33
) (
    input logic clk,
    input logic rst,
    div_if.slave bus
);
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;

    logic [2*WIDTH-1:0] rem;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem_hi;
    logic [WIDTH-1:0]   alu_out;
    logic [5:0]         shcnt;
    logic [6:0]         shcnt_nxt;
`ifdef DIV_DIVZERO_EN
    logic [WIDTH-1:0]   dvd_q;
`endif

    always_comb begin
        rem_hi    = rem[2*WIDTH-1:WIDTH];
        shcnt_nxt = {1'b0, shcnt} + 7'd1;
        case (bus.ALUfunction)
            ALU_ADD: alu_out = rem_hi + dsr;
            ALU_SUB: alu_out = rem_hi - dsr;
            default: alu_out = rem_hi;
        endcase
    end

    assign bus.fsb = rem[2*WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem           <= '0;
            dsr           <= '0;
            shcnt         <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
`ifdef DIV_DIVZERO_EN
            bus.dz        <= 1'b0;
            dvd_q         <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (bus.run) begin
                // Dividend enters pre-shifted by one so the first subtract sees its MSB.
                rem      <= {{(WIDTH-1){1'b0}}, bus.dividend, 1'b0};
                dsr      <= bus.divisor;
                shcnt    <= '0;
                bus.busy <= 1'b1;
                bus.err  <= 1'b0;
`ifdef DIV_DIVZERO_EN
                bus.dz   <= (bus.divisor == '0);
                dvd_q    <= bus.dividend;
`endif
            end else if (bus.ready) begin
                if (bus.busy) begin
`ifdef DIV_DIVZERO_EN
                    if (bus.dz) begin
                        bus.quotient  <= '1;
                        bus.remainder <= dvd_q;
                    end else begin
                        bus.quotient  <= rem[WIDTH-1:0];
                        bus.remainder <= rem[2*WIDTH-1:WIDTH];
                    end
`else
                    bus.quotient  <= rem[WIDTH-1:0];
                    bus.remainder <= rem[2*WIDTH-1:WIDTH];
`endif
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end else begin
                    bus.err <= 1'b1;
                end
            end else if (bus.busy) begin
                if (bus.ready_wait) begin
                    rem[2*WIDTH-1:WIDTH] <= {1'b0, rem[2*WIDTH-1:WIDTH+1]};
                end else if (bus.wrctrl) begin
                    rem[2*WIDTH-1:WIDTH] <= alu_out;
                end else begin
                    rem   <= {rem[2*WIDTH-2:0], bus.ozctrl};
                    shcnt <= shcnt_nxt[5:0];
                    if (shcnt_nxt > 7'(MAXSHIFT))
                        bus.err <= 1'b1;
                end
            end
        end
    end
endmodule
